// File: rtl/lcd_bl_ctrl.sv
// Front-panel LCD backlight controller: OFF / fade-in / active / timeout fade-out / dark
// sequencing with a free-running 8-bit PWM on lcd_bl at the applied duty.
module lcd_bl_ctrl #(
    parameter int TICK_DIV    = 27000,
    parameter int FADE_IN_MS  = 1,
    parameter int FADE_OUT_MS = 4
) (
    input  logic       clk27,
    input  logic       reset_n,
    input  logic       bl_on,
    input  logic [1:0] bl_time,
    input  logic [7:0] bl_level,
    input  logic       remote_event,
    input  logic       force_on,
    output logic       lcd_bl,
    output logic [2:0] bl_state,
    output logic [7:0] bl_duty
);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_FADE_IN  = 3'd1,
        S_ACTIVE   = 3'd2,
        S_FADE_OUT = 3'd3,
        S_DARK     = 3'd4
    } state_t;

    localparam int          PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam int          SW         = 16;
    localparam logic [SW-1:0] FI_LAST  = SW'(FADE_IN_MS - 1);
    localparam logic [SW-1:0] FO_LAST  = SW'(FADE_OUT_MS - 1);
    localparam logic [14:0] MS_MAX     = 15'h7FFF;

    state_t        r_state;
    logic [7:0]    r_duty;
    logic [SW-1:0] r_step;
    logic [PW-1:0] r_presc;
    logic [14:0]   r_ms_cnt;
    logic [7:0]    r_pwm_cnt;
    logic          r_event_prev;
    logic          r_lcd_bl;

    logic          w_tick;
    logic          w_act;
    logic          w_enter_active;
    logic          w_timeout;
    logic [14:0]   w_limit;

    function automatic logic [14:0] timeout_limit(input logic [1:0] sel);
        case (sel)
            2'd1:    timeout_limit = 15'd3000;
            2'd2:    timeout_limit = 15'd10000;
            2'd3:    timeout_limit = 15'd30000;
            default: timeout_limit = 15'd0;
        endcase
    endfunction

    assign w_tick         = (r_presc == PRESC_MAX);
    assign w_act          = (remote_event != r_event_prev) | force_on;
    assign w_enter_active = bl_on && (r_state == S_FADE_IN) && (r_duty >= bl_level);
    assign w_limit        = timeout_limit(bl_time);
    assign w_timeout      = (bl_time != 2'd0) && !force_on && (r_ms_cnt >= w_limit);

    // Millisecond prescaler: free-running, never disturbed by activity or state.
    // NOTE: every register here uses <= so all blocks see pre-edge values of each other.
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            r_event_prev <= 1'b0;
        end else begin
            r_event_prev <= remote_event;
        end
    end

    // Idle timer: restarts on activity or ACTIVE entry, otherwise saturating ms count.
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            r_ms_cnt <= '0;
        end else if (w_act || w_enter_active) begin
            r_ms_cnt <= '0;
        end else if (w_tick && (r_ms_cnt != MS_MAX)) begin
            r_ms_cnt <= r_ms_cnt + 15'd1;
        end
    end

    // Backlight sequencer; bl_on low overrides everything.
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_OFF;
            r_duty  <= '0;
            r_step  <= '0;
        end else if (!bl_on) begin
            r_state <= S_OFF;
            r_duty  <= '0;
            r_step  <= '0;
        end else begin
            case (r_state)
                S_OFF: begin
                    r_state <= S_FADE_IN;
                    r_duty  <= '0;
                    r_step  <= '0;
                end
                S_FADE_IN: begin
                    if (w_enter_active) begin
                        r_state <= S_ACTIVE;
                        r_duty  <= bl_level;
                        r_step  <= '0;
                    end else if (w_tick) begin
                        if (r_step == FI_LAST) begin
                            r_duty <= r_duty + 8'd1;
                            r_step <= '0;
                        end else begin
                            r_step <= r_step + 1'b1;
                        end
                    end
                end
                S_ACTIVE: begin
                    r_duty <= bl_level;
                    // Activity in the same cycle as the timeout keeps the panel lit.
                    if (!w_act && w_timeout) begin
                        r_state <= S_FADE_OUT;
                        r_step  <= '0;
                    end
                end
                S_FADE_OUT: begin
                    if (w_act) begin
                        r_state <= S_FADE_IN;
                        r_step  <= '0;
                    end else if (r_duty == 8'd0) begin
                        r_state <= S_DARK;
                        r_step  <= '0;
                    end else if (w_tick) begin
                        if (r_step == FO_LAST) begin
                            r_duty <= r_duty - 8'd1;
                            r_step <= '0;
                        end else begin
                            r_step <= r_step + 1'b1;
                        end
                    end
                end
                S_DARK: begin
                    r_duty <= '0;
                    if (w_act) begin
                        r_state <= S_FADE_IN;
                        r_step  <= '0;
                    end
                end
                default: begin
                    r_state <= S_OFF;
                    r_duty  <= '0;
                    r_step  <= '0;
                end
            endcase
        end
    end

    // PWM: duty 255 is forced to a constant high so full brightness has no gap.
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            r_pwm_cnt <= '0;
            r_lcd_bl  <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            r_lcd_bl  <= bl_on & ((r_duty == 8'hFF) | (r_pwm_cnt < r_duty));
        end
    end

    assign lcd_bl   = r_lcd_bl;
    assign bl_state = r_state;
    assign bl_duty  = r_duty;

endmodule

// File: tb/tb_lcd_bl_ctrl.sv
// Directed bench for lcd_bl_ctrl at TICK_DIV=10: fade-in, timeout/fade-out, wake-up,
// force_on hold, PWM extremes, bl_on drop and asynchronous reset.
module tb_lcd_bl_ctrl;

    localparam logic [2:0] ST_OFF      = 3'd0;
    localparam logic [2:0] ST_FADE_IN  = 3'd1;
    localparam logic [2:0] ST_ACTIVE   = 3'd2;
    localparam logic [2:0] ST_FADE_OUT = 3'd3;
    localparam logic [2:0] ST_DARK     = 3'd4;

    logic       clk27        = 1'b0;
    logic       reset_n      = 1'b0;
    logic       bl_on        = 1'b0;
    logic [1:0] bl_time      = 2'd0;
    logic [7:0] bl_level     = 8'd0;
    logic       remote_event = 1'b0;
    logic       force_on     = 1'b0;
    logic       lcd_bl;
    logic [2:0] bl_state;
    logic [7:0] bl_duty;

    int n_pass  = 0;
    int n_total = 0;
    int n;
    int hi;

    lcd_bl_ctrl #(
        .TICK_DIV    (10),
        .FADE_IN_MS  (1),
        .FADE_OUT_MS (4)
    ) dut (
        .clk27        (clk27),
        .reset_n      (reset_n),
        .bl_on        (bl_on),
        .bl_time      (bl_time),
        .bl_level     (bl_level),
        .remote_event (remote_event),
        .force_on     (force_on),
        .lcd_bl       (lcd_bl),
        .bl_state     (bl_state),
        .bl_duty      (bl_duty)
    );

    always #5 clk27 = ~clk27;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi_lim);
        n_total++;
        assert (obs >= lo && obs <= hi_lim) n_pass++;
        else $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi_lim);
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk27);
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, output int cnt);
        cnt = 0;
        while (bl_state !== st && cnt < budget) begin
            @(negedge clk27);
            cnt++;
        end
    endtask

    task automatic wait_duty(input logic [7:0] d, input int budget, output int cnt);
        cnt = 0;
        while (bl_duty !== d && cnt < budget) begin
            @(negedge clk27);
            cnt++;
        end
    endtask

    task automatic count_high(input int k, output int cnt);
        cnt = 0;
        repeat (k) begin
            @(negedge clk27);
            if (lcd_bl === 1'b1) cnt++;
        end
    endtask

    initial begin
        // Reset state
        cyc(3);
        chk("rst_state", bl_state, ST_OFF);
        chk("rst_duty", bl_duty, 0);
        chk("rst_lcd", lcd_bl, 0);

        // 1: fade in to 128 at +1 per ms
        reset_n  = 1'b1;
        bl_on    = 1'b1;
        bl_level = 8'd128;
        cyc(1);
        chk("fi_entry_state", bl_state, ST_FADE_IN);
        chk("fi_entry_duty", bl_duty, 0);
        cyc(100);
        chk_rng("fi_duty_100clk", bl_duty, 9, 11);
        wait_state(ST_ACTIVE, 2000, n);
        chk("fi_reach_active", bl_state, ST_ACTIVE);
        chk_rng("fi_active_latency", n, 1160, 1200);
        chk("active_duty", bl_duty, 128);
        cyc(1);
        count_high(256, hi);
        chk("pwm_128_of_256", hi, 128);

        // 2: 3000 ms timeout then fade out at -1 per 4 ms
        bl_time      = 2'd1;
        remote_event = ~remote_event;
        wait_state(ST_FADE_OUT, 31000, n);
        chk("to1_reach_fade_out", bl_state, ST_FADE_OUT);
        chk_rng("to1_latency", n, 29985, 30015);

        // 3: activity at duty 60 resumes fading in from 60
        wait_duty(8'd60, 3000, n);
        chk("fo_reach_60", bl_duty, 60);
        chk_rng("fo_128_to_60_latency", n, 2700, 2730);
        remote_event = ~remote_event;
        cyc(1);
        chk("wake_state", bl_state, ST_FADE_IN);
        chk("wake_duty", bl_duty, 60);
        cyc(25);
        chk_rng("wake_duty_rising", bl_duty, 61, 63);
        chk("wake_still_fading", bl_state, ST_FADE_IN);

        // Level lowered below current duty during fade-in
        bl_level = 8'd50;
        cyc(1);
        chk("lower_level_state", bl_state, ST_ACTIVE);
        chk("lower_level_duty", bl_duty, 50);

        // 2 (cont.): timeout again and fade all the way to DARK
        wait_state(ST_FADE_OUT, 31000, n);
        chk("to2_reach_fade_out", bl_state, ST_FADE_OUT);
        chk_rng("to2_latency", n, 29985, 30015);
        wait_state(ST_DARK, 2500, n);
        chk("reach_dark", bl_state, ST_DARK);
        chk_rng("fo_50_to_dark_latency", n, 1980, 2015);
        chk("dark_duty", bl_duty, 0);
        cyc(2);
        count_high(64, hi);
        chk("dark_lcd_low", hi, 0);

        // 4: force_on wakes from DARK and suppresses the timeout
        force_on = 1'b1;
        cyc(1);
        chk("force_wake_state", bl_state, ST_FADE_IN);
        wait_state(ST_ACTIVE, 1000, n);
        chk("force_reach_active", bl_state, ST_ACTIVE);
        chk_rng("force_fi_latency", n, 490, 515);
        chk("force_active_duty", bl_duty, 50);
        hi = 0;
        repeat (6000) begin
            @(negedge clk27);
            if (bl_state !== ST_ACTIVE) hi++;
        end
        chk("force_hold_no_timeout", hi, 0);

        // 6: PWM extremes in ACTIVE
        bl_level = 8'd255;
        cyc(2);
        chk("full_duty", bl_duty, 255);
        count_high(512, hi);
        chk("pwm_255_const_high", hi, 512);
        bl_level = 8'd0;
        cyc(2);
        chk("zero_duty", bl_duty, 0);
        count_high(512, hi);
        chk("pwm_0_const_low", hi, 0);
        force_on = 1'b0;

        // 5: bl_on drop mid fade-in, then reset mid fade-in
        bl_level = 8'd128;
        bl_on    = 1'b0;
        cyc(1);
        chk("off_state", bl_state, ST_OFF);
        bl_on = 1'b1;
        cyc(1);
        chk("refade_state", bl_state, ST_FADE_IN);
        cyc(200);
        chk_rng("refade_duty_200clk", bl_duty, 19, 21);
        bl_on = 1'b0;
        cyc(1);
        chk("drop_state", bl_state, ST_OFF);
        chk("drop_duty", bl_duty, 0);
        cyc(1);
        chk("drop_lcd", lcd_bl, 0);
        bl_on = 1'b1;
        cyc(150);
        chk_rng("pre_reset_duty", bl_duty, 14, 16);
        reset_n = 1'b0;
        #1;
        chk("areset_state", bl_state, ST_OFF);
        chk("areset_duty", bl_duty, 0);
        chk("areset_lcd", lcd_bl, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
